// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: BIOS/IMEM address generation, stall hold,
// one-bubble redirects, unmapped-fetch fault flag and performance counters.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   RUN   | advancing: pc_d1 <= pc_q, pc_q <= pc_q + 4 each cycle
//   STALL | holding pc_q/pc_d1; memories re-read pc_d1 so inst stays put
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] bios_dout,
    input  logic [31:0] imem_dout,
    output logic [11:0] bios_addr,
    output logic [13:0] imem_addr,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    output logic        fetch_fault,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {RUN, STALL} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_d1_q, pc_d1_d;
    logic        fault_q, fault_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    logic [31:0] redirect_target;
    logic [31:0] fetch_addr;
    logic        src_bios;
    logic        src_imem;
    logic        unmapped;

    // Address and data path
    always_comb begin
        redirect_target = {redirect_pc[31:2], 2'b00};
        if (rst)
            fetch_addr = RESET_PC;
        else if (redirect_valid)
            fetch_addr = redirect_target;
        else if (stall)
            fetch_addr = pc_d1_q;
        else
            fetch_addr = pc_q;

        bios_addr = fetch_addr[13:2];
        imem_addr = fetch_addr[15:2];

        src_bios = (pc_d1_q[31:28] == 4'h4);
        src_imem = (pc_d1_q[31:28] == 4'h1);
        unmapped = !src_bios && !src_imem;

        inst       = NOP;
        inst_valid = 1'b0;
        if (!rst && !redirect_valid && !unmapped) begin
            inst       = src_bios ? bios_dout : imem_dout;
            inst_valid = 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_d1_d      = pc_d1_q;
        fault_d      = fault_q;
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;

        if (rst) begin
            state_d      = RUN;
            pc_d1_d      = RESET_PC;
            pc_d         = RESET_PC + 32'd4;
            fault_d      = 1'b0;
            fetch_cnt_d  = 32'd0;
            bubble_cnt_d = 32'd0;
        end else begin
            case (state_q)
                RUN:     if (stall && !redirect_valid) state_d = STALL;
                STALL:   if (!stall || redirect_valid) state_d = RUN;
                default: state_d = RUN;
            endcase

            // A redirect overrides stall; an unredirected stall holds both PCs.
            if (redirect_valid) begin
                pc_d1_d = redirect_target;
                pc_d    = redirect_target + 32'd4;
            end else if (!stall) begin
                pc_d1_d = pc_q;
                pc_d    = pc_q + 32'd4;
            end

            if (unmapped)
                fault_d = 1'b1;
            if (inst_valid && !stall)
                fetch_cnt_d = fetch_cnt_q + 32'd1;
            if (!inst_valid)
                bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        state_q      <= state_d;
        pc_q         <= pc_d;
        pc_d1_q      <= pc_d1_d;
        fault_q      <= fault_d;
        fetch_cnt_q  <= fetch_cnt_d;
        bubble_cnt_q <= bubble_cnt_d;
    end

    // The fault flag is visible in the same cycle the unmapped fetch is seen.
    assign fetch_fault  = fault_q || (unmapped && !rst);
    assign inst_pc      = pc_d1_q;
    assign fetch_count  = fetch_cnt_q;
    assign bubble_count = bubble_cnt_q;

endmodule
